dram_target: RTL
================

# dram_target

Memory-side responder for the shared DRAM port driven by the dual-core bus arbiter. Accepts one load or store strobe at a time on the `w_dram_*` interface, holds `w_dram_busy` while the access is in flight, and performs byte/halfword/word access with RISC-V size and sign semantics. Read data is presented on `w_dram_odata` when busy falls. Backing store is an internal synchronous RAM, so the arbiter can be exercised against a real target in simulation and on FPGA.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits. Store is 2^ADDR_WIDTH 32-bit words (16 KiB at default).
- `LATENCY`, default 2, legal range 1..15: access cycles before the RAM operation issues.
- `CLK  in  1`: clock; all state changes on the rising edge.
- `RST_X  in  1`: reset. Asynchronous, active-low.
- `w_dram_addr  in  32`: byte address. Sampled on accept.
- `w_dram_wdata  in  32`: store data, right-aligned. Sampled on accept.
- `w_dram_ctrl  in  3`: funct3 size code. Sampled on accept.
- `w_dram_le  in  1`: load strobe.
- `w_dram_we_t  in  1`: store strobe.
- `w_dram_odata  out  32`: load result, sign- or zero-extended.
- `w_dram_busy  out  1`: access in flight.
- `w_dram_err  out  1`: last accepted request was illegal.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `busy` = 0.
  - If `le | we_t` is 1 at an edge, the request is accepted: latch addr, ctrl and wdata; set `busy` = 1; load counter with `LATENCY`; clear `err`; go to ACCESS.
- **ACCESS**
  - Strobes are ignored. The arbiter drops them after it sees busy.
  - Counter decrements each edge.
  - On the edge where counter == 1, issue the RAM operation and go to RESP.
- **RESP**
  - Next edge: `odata` <= extended read data (loads only); `busy` <= 0; go to IDLE.
  - Stores leave `odata` unchanged.
- **Size codes (ctrl)**
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Stores use 000, 001, 010 only.
- **Store lanes**
  - SB: `wdata[7:0]` written to lane `addr[1:0]`, byte enable one-hot.
  - SH: `wdata[15:0]` written to lane `addr[1]`, enables 0011 or 1100.
  - SW: all four lanes.
- **Load extraction**
  - Selected lane(s) shifted down to bit 0.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- **Word index** = `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses alias (wrap) modulo the store size.
- **Illegal requests** (full busy sequence still runs):
  - The cases: `le` and `we_t` both 1; H/HU/SH with `addr[0]` = 1; W with `addr[1:0]` != 0; any ctrl outside the legal set for the direction.
  - Required behaviour: no RAM write; `odata` <= 0 at RESP; `err` <= 1 at accept+1 cycle, held until the next accept.
- Memory contents are not initialised or reset. Simulation may preload the RAM through `$readmemh`.

## Timing
- Reset values: `w_dram_busy` = 0, `w_dram_odata` = 0, `w_dram_err` = 0, state IDLE, counter 0.
- Busy rises the cycle after accept and stays high for exactly `LATENCY`+1 cycles. Busy-to-busy spacing is at least 1 idle cycle.
- `odata` is valid in the same cycle busy falls and stays stable until the RESP edge of the next load.
- Back-to-back: a strobe present on the edge busy falls is not accepted. It is accepted on the following edge if it is still held.
- Strobe asserted for 1 cycle only: accepted, full access completes.
- Reset mid-ACCESS: access aborted, no RAM write if the issue edge was not reached; outputs return to reset values immediately.
- Reset mid-RESP: a write already issued stays in memory.
- `LATENCY` = 1: ACCESS lasts 1 cycle; busy is high for 2 cycles.

## Structure
- Add size-code constants (`DRAM_SB`, `DRAM_SH`, `DRAM_SW`, `DRAM_LBU`, `DRAM_LHU`) and FSM state encodings to `define.vh`, shared with the arbiter and cores.
- Sub-module `dram_bank`: single-port synchronous RAM, 32-bit wide, 4 byte enables, registered read, parameterised by `ADDR_WIDTH`.
- FSM, lane logic, extension and error check live in `dram_target`.

## Test plan
- **SW then LW**, `LATENCY`=2: SW addr 0x10 data 0xDEADBEEF; LW 0x10. Busy high 3 cycles per access; `odata` = 0xDEADBEEF, `err` = 0.
- **SB into word, then LB/LBU**: SB 0x80 to addr 0x13 over 0x11223344 at 0x10. LW 0x10 = 0x80223344. LB 0x13 = 0xFFFFFF80. LBU 0x13 = 0x00000080.
- **SH and LH/LHU**: SH 0xF00D at 0x22. LH 0x22 = 0xFFFFF00D; LHU 0x22 = 0x0000F00D; low half at 0x20 unchanged.
- **Misaligned LW at 0x06**: busy sequence runs, `odata` = 0, `err` = 1. A following legal LW clears `err`.
- **Wrap-around and illegal store**: `ADDR_WIDTH`=12, SW 0x4000 data 0x5A5A5A5A; LW 0x0 returns 0x5A5A5A5A. Simultaneous `le`+`we_t` → `err` = 1, memory unchanged.
- **Reset mid-ACCESS**: `LATENCY`=4, SW 0x30 data 1, deassert `RST_X` 2 cycles after accept. Busy drops asynchronously; a later LW 0x30 returns the prior value.

Source files
------------

// File: rtl/dram_target_pkg.sv
// Shared constants for the DRAM target: funct3 size codes and FSM state encodings,
// used by the target, the bus arbiter and the cores.
package dram_target_pkg;

  localparam logic [2:0] DRAM_SB  = 3'b000;
  localparam logic [2:0] DRAM_SH  = 3'b001;
  localparam logic [2:0] DRAM_SW  = 3'b010;
  localparam logic [2:0] DRAM_LB  = 3'b000;
  localparam logic [2:0] DRAM_LH  = 3'b001;
  localparam logic [2:0] DRAM_LW  = 3'b010;
  localparam logic [2:0] DRAM_LBU = 3'b100;
  localparam logic [2:0] DRAM_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/dram_target_if.sv
// Strobe/busy handshake between the bus arbiter (master) and the DRAM target (slave).
interface dram_target_if;

  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_le;
  logic        w_dram_we_t;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;
  logic        w_dram_err;

  modport master (
    output w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t,
    input  w_dram_odata, w_dram_busy, w_dram_err
  );

  modport slave (
    input  w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t,
    output w_dram_odata, w_dram_busy, w_dram_err
  );

endinterface

// File: rtl/dram_bank.sv
// Single-port synchronous RAM, 32-bit words with per-byte enables and a registered read.
module dram_bank #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Read returns the pre-write contents when a write hits the same word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dram_target.sv
// DRAM-side responder: accepts one load/store strobe, holds busy for LATENCY+1 cycles,
// and performs RISC-V sized accesses against an internal RAM bank.
module dram_target
  import dram_target_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RST_X,
  dram_target_if.slave bus
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  busy;
  logic                  err;
  logic [31:0]           odata;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            ctrl_q;
  logic                  store_q;
  logic                  bad_q;
  logic [31:0]           rdata;
  logic                  accept;
  logic                  issue;
  logic                  req_bad;
  logic                  unused_addr_hi;

  function automatic logic is_illegal(input logic le, input logic we_t,
                                      input logic [2:0] ctrl, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (le && we_t) begin
      bad = 1'b1;
    end else if (we_t) begin
      case (ctrl)
        DRAM_SB: bad = 1'b0;
        DRAM_SH: bad = lsb[0];
        DRAM_SW: bad = (lsb != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (ctrl)
        DRAM_LB, DRAM_LBU: bad = 1'b0;
        DRAM_LH, DRAM_LHU: bad = lsb[0];
        DRAM_LW:           bad = (lsb != 2'b00);
        default:           bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] ctrl, input logic [1:0] lsb);
    logic [3:0] be;
    case (ctrl)
      DRAM_SB: be = 4'b0001 << lsb;
      DRAM_SH: be = lsb[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the right-aligned data lets the byte enables pick the target lane.
  function automatic logic [31:0] store_lanes(input logic [2:0] ctrl, input logic [31:0] wd);
    logic [31:0] lanes;
    case (ctrl)
      DRAM_SB: lanes = {4{wd[7:0]}};
      DRAM_SH: lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] ctrl, input logic [1:0] lsb,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> {lsb, 3'b000};
    case (ctrl)
      DRAM_LB:  res = {{24{sh[7]}}, sh[7:0]};
      DRAM_LBU: res = {24'h0, sh[7:0]};
      DRAM_LH:  res = {{16{sh[15]}}, sh[15:0]};
      DRAM_LHU: res = {16'h0, sh[15:0]};
      default:  res = rd;
    endcase
    return res;
  endfunction

  assign accept  = (state == ST_IDLE) && (bus.w_dram_le || bus.w_dram_we_t);
  assign issue   = (state == ST_ACCESS) && (cnt == 4'd1);
  assign req_bad = is_illegal(bus.w_dram_le, bus.w_dram_we_t, bus.w_dram_ctrl,
                              bus.w_dram_addr[1:0]);
  assign unused_addr_hi = ^bus.w_dram_addr[31:ADDR_WIDTH+2];

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      err   <= 1'b0;
      odata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_ACCESS;
            cnt   <= LAT;
            busy  <= 1'b1;
            err   <= req_bad;
          end
        end
        ST_ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (bad_q)         odata <= 32'h0;
          else if (!store_q) odata <= load_ext(ctrl_q, addr_q[1:0], rdata);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request capture: data-only, reloaded on every accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= bus.w_dram_addr[ADDR_WIDTH+1:0];
      wdata_q <= bus.w_dram_wdata;
      ctrl_q  <= bus.w_dram_ctrl;
      store_q <= bus.w_dram_we_t;
      bad_q   <= req_bad;
    end
  end

  dram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk   (CLK),
    .en    (issue),
    .be    ((store_q && !bad_q) ? store_be(ctrl_q, addr_q[1:0]) : 4'b0000),
    .addr  (addr_q[ADDR_WIDTH+1:2]),
    .wdata (store_lanes(ctrl_q, wdata_q)),
    .rdata (rdata)
  );

  assign bus.w_dram_odata = odata;
  assign bus.w_dram_busy  = busy;
  assign bus.w_dram_err   = err;

endmodule
